// File: rtl/veri_pkg.sv
// Shared encodings for the VERI_RISC sequencer: opcodes, instruction-cycle
// states and opcode classification.
package veri_pkg;

  localparam logic [2:0] OPC_HLT = 3'd0;
  localparam logic [2:0] OPC_SKZ = 3'd1;
  localparam logic [2:0] OPC_ADD = 3'd2;
  localparam logic [2:0] OPC_AND = 3'd3;
  localparam logic [2:0] OPC_XOR = 3'd4;
  localparam logic [2:0] OPC_LDA = 3'd5;
  localparam logic [2:0] OPC_STO = 3'd6;
  localparam logic [2:0] OPC_JMP = 3'd7;

  // Low three bits of the P-states equal the visible phase number
  typedef enum logic [3:0] {
    P_INST_ADDR  = 4'd0,
    P_INST_FETCH = 4'd1,
    P_INST_LOAD  = 4'd2,
    P_IDLE       = 4'd3,
    P_OP_ADDR    = 4'd4,
    P_OP_FETCH   = 4'd5,
    P_ALU_OP     = 4'd6,
    P_STORE      = 4'd7,
    HALTED       = 4'd8
  } state_e;

  function automatic logic is_alu_op(input logic [2:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_AND) ||
           (opc == OPC_XOR) || (opc == OPC_LDA);
  endfunction

endpackage

// File: rtl/veri_wait_timer.sv
// Memory wait-state watchdog: counts stalled cycles in an access phase and
// raises a sticky bus error when the limit is reached.
module veri_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stall,
  input  logic advance,
  output logic expire,
  output logic bus_err
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;

  always_comb begin
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    expire    = 1'b0;
    if (en) begin
      if (stall && !advance) begin
        if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          expire    = 1'b1;
          bus_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;

endmodule

// File: rtl/veri_sequencer.sv
// VERI_RISC control unit: 8-phase instruction-cycle FSM with memory wait
// states, HALTED/resume, global enable and bus-timeout, plus strobe decode.
module veri_sequencer
  import veri_pkg::*;
#(
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             resume,
  input  logic             zero,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             halt,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic [2:0]       phase,
  output logic             halted,
  output logic             bus_err
);

  state_e     state_q, state_d;
  logic [3:0] st_bits;
  logic [2:0] opc_lo;
  logic       opc_known, is_hlt, alu_op, skz, jmp, sto;
  logic       access, stall, advance, expire;

  assign st_bits   = state_q;
  assign opc_lo    = opcode[2:0];
  // Any opcode with bits set above the 3-bit field decodes as NOP
  assign opc_known = ((opcode >> 3) == '0);
  assign is_hlt    = opc_known && (opc_lo == OPC_HLT);
  assign alu_op    = opc_known && is_alu_op(opc_lo);
  assign skz       = opc_known && (opc_lo == OPC_SKZ) && zero;
  assign jmp       = opc_known && (opc_lo == OPC_JMP);
  assign sto       = opc_known && (opc_lo == OPC_STO);

  always_comb begin
    case (state_q)
      P_INST_FETCH: access = 1'b1;
      P_OP_FETCH:   access = alu_op;
      P_STORE:      access = sto;
      default:      access = 1'b0;
    endcase
  end

  assign stall   = access && !mem_ready;
  assign advance = en && !stall;

  veri_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .stall   (stall),
    .advance (advance),
    .expire  (expire),
    .bus_err (bus_err)
  );

  always_comb begin
    state_d = state_q;
    if (en) begin
      if (state_q == HALTED) begin
        if (resume && !bus_err) state_d = P_INST_ADDR;
      end else if (expire) begin
        state_d = HALTED;
      end else if (!stall) begin
        if ((state_q == P_OP_ADDR) && is_hlt) state_d = HALTED;
        else state_d = state_e'({1'b0, st_bits[2:0] + 3'd1});
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= P_INST_ADDR;
    else      state_q <= state_d;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    halted = 1'b0;
    phase  = st_bits[2:0];
    case (state_q)
      P_INST_ADDR: sel = 1'b1;
      P_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      P_INST_LOAD, P_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      P_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      P_OP_FETCH: rd = alu_op;
      P_ALU_OP: begin
        rd     = alu_op;
        inc_pc = skz;
        ld_pc  = jmp;
        data_e = sto;
      end
      P_STORE: begin
        rd     = alu_op;
        ld_ac  = alu_op;
        ld_pc  = jmp;
        wr     = sto;
        data_e = sto;
      end
      HALTED: begin
        halt   = 1'b1;
        halted = 1'b1;
        phase  = 3'd4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_veri_sequencer.sv
// Directed bench for veri_sequencer: expected output vectors are queued as
// each step is driven and popped/compared once the outputs have settled.
module tb_veri_sequencer;

  localparam logic [8:0] S_SEL  = 9'h100;
  localparam logic [8:0] S_RD   = 9'h080;
  localparam logic [8:0] S_LDIR = 9'h040;
  localparam logic [8:0] S_INC  = 9'h020;
  localparam logic [8:0] S_HALT = 9'h010;
  localparam logic [8:0] S_LDPC = 9'h008;
  localparam logic [8:0] S_DE   = 9'h004;
  localparam logic [8:0] S_LDAC = 9'h002;
  localparam logic [8:0] S_WR   = 9'h001;
  localparam logic [8:0] S_NONE = 9'h000;

  logic       clk = 1'b0;
  logic       rst, en, resume, zero, mem_ready;
  logic [3:0] opcode;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;
  logic       halted, bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;
  exp_t exp_q[$];

  veri_sequencer #(.OPC_W(4), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .resume    (resume),
    .zero      (zero),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .halt      (halt),
    .ld_pc     (ld_pc),
    .data_e    (data_e),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .phase     (phase),
    .halted    (halted),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string tag, input logic [8:0] stb, input logic [2:0] ph,
                            input logic hl, input logic be);
    exp_t e, got;
    logic [14:0] obs;
    e.tag = tag;
    e.v   = {stb, ph, hl, be};
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    obs = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase, halted, bus_err};
    checks++;
    assert (obs === got.v) else begin
      errors++;
      $error("FAIL %s observed %b expected %b (strobes|phase|halted|bus_err)", got.tag, obs, got.v);
    end
  endtask

  task automatic fetch(input string t);
    expect_now({t, "_p0"}, S_SEL, 3'd0, 1'b0, 1'b0);               tick();
    expect_now({t, "_p1"}, S_SEL | S_RD, 3'd1, 1'b0, 1'b0);        tick();
    expect_now({t, "_p2"}, S_SEL | S_RD | S_LDIR, 3'd2, 1'b0, 1'b0); tick();
    expect_now({t, "_p3"}, S_SEL | S_RD | S_LDIR, 3'd3, 1'b0, 1'b0); tick();
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; resume = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = 4'd2;
    #2;
    expect_now("rst_p0", S_SEL, 3'd0, 1'b0, 1'b0);
    tick();
    expect_now("rst_hold", S_SEL, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;

    // ADD, no wait states
    fetch("add");
    expect_now("add_p4", S_INC, 3'd4, 1'b0, 1'b0);         tick();
    expect_now("add_p5", S_RD, 3'd5, 1'b0, 1'b0);          tick();
    expect_now("add_p6", S_RD, 3'd6, 1'b0, 1'b0);          tick();
    expect_now("add_p7", S_RD | S_LDAC, 3'd7, 1'b0, 1'b0); tick();

    // LDA with three wait states in P1
    opcode = 4'd5;
    expect_now("lda_p0", S_SEL, 3'd0, 1'b0, 1'b0); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_now("lda_p1_wait", S_SEL | S_RD, 3'd1, 1'b0, 1'b0); tick();
    end
    mem_ready = 1'b1;
    expect_now("lda_p1_go", S_SEL | S_RD, 3'd1, 1'b0, 1'b0);        tick();
    expect_now("lda_p2", S_SEL | S_RD | S_LDIR, 3'd2, 1'b0, 1'b0);  tick();
    expect_now("lda_p3", S_SEL | S_RD | S_LDIR, 3'd3, 1'b0, 1'b0);  tick();
    expect_now("lda_p4", S_INC, 3'd4, 1'b0, 1'b0);                  tick();
    expect_now("lda_p5", S_RD, 3'd5, 1'b0, 1'b0);                   tick();
    expect_now("lda_p6", S_RD, 3'd6, 1'b0, 1'b0);                   tick();
    expect_now("lda_p7", S_RD | S_LDAC, 3'd7, 1'b0, 1'b0);          tick();

    // HLT, hold, resume
    opcode = 4'd0;
    fetch("hlt");
    expect_now("hlt_p4", S_INC | S_HALT, 3'd4, 1'b0, 1'b0); tick();
    for (int i = 0; i < 20; i++) begin
      expect_now("hlt_held", S_HALT, 3'd4, 1'b1, 1'b0); tick();
    end
    en = 1'b0; resume = 1'b1;
    tick();
    expect_now("hlt_resume_en0", S_HALT, 3'd4, 1'b1, 1'b0);
    en = 1'b1;
    expect_now("hlt_resume_pend", S_HALT, 3'd4, 1'b1, 1'b0); tick();
    resume = 1'b0;
    expect_now("hlt_resumed", S_SEL, 3'd0, 1'b0, 1'b0);

    // SKZ with zero set, then clear
    opcode = 4'd1; zero = 1'b1;
    fetch("skz1");
    expect_now("skz1_p4", S_INC, 3'd4, 1'b0, 1'b0);  tick();
    expect_now("skz1_p5", S_NONE, 3'd5, 1'b0, 1'b0); tick();
    expect_now("skz1_p6", S_INC, 3'd6, 1'b0, 1'b0);  tick();
    expect_now("skz1_p7", S_NONE, 3'd7, 1'b0, 1'b0); tick();
    zero = 1'b0;
    fetch("skz0");
    expect_now("skz0_p4", S_INC, 3'd4, 1'b0, 1'b0);  tick();
    expect_now("skz0_p5", S_NONE, 3'd5, 1'b0, 1'b0); tick();
    expect_now("skz0_p6", S_NONE, 3'd6, 1'b0, 1'b0); tick();
    expect_now("skz0_p7", S_NONE, 3'd7, 1'b0, 1'b0); tick();

    // JMP
    opcode = 4'd7;
    fetch("jmp");
    expect_now("jmp_p4", S_INC, 3'd4, 1'b0, 1'b0);  tick();
    expect_now("jmp_p5", S_NONE, 3'd5, 1'b0, 1'b0); tick();
    expect_now("jmp_p6", S_LDPC, 3'd6, 1'b0, 1'b0); tick();
    expect_now("jmp_p7", S_LDPC, 3'd7, 1'b0, 1'b0); tick();

    // STO with two wait states in P7
    opcode = 4'd6;
    fetch("sto");
    expect_now("sto_p4", S_INC, 3'd4, 1'b0, 1'b0);  tick();
    expect_now("sto_p5", S_NONE, 3'd5, 1'b0, 1'b0); tick();
    expect_now("sto_p6", S_DE, 3'd6, 1'b0, 1'b0);   tick();
    mem_ready = 1'b0;
    expect_now("sto_p7_wait", S_DE | S_WR, 3'd7, 1'b0, 1'b0); tick();
    expect_now("sto_p7_wait", S_DE | S_WR, 3'd7, 1'b0, 1'b0); tick();
    mem_ready = 1'b1;
    expect_now("sto_p7_go", S_DE | S_WR, 3'd7, 1'b0, 1'b0);   tick();

    // Out-of-range opcodes are NOPs: no halt, no access in P5/P7
    opcode = 4'd8;
    fetch("nop8");
    expect_now("nop8_p4", S_INC, 3'd4, 1'b0, 1'b0); tick();
    mem_ready = 1'b0;
    expect_now("nop8_p5", S_NONE, 3'd5, 1'b0, 1'b0); tick();
    expect_now("nop8_p6", S_NONE, 3'd6, 1'b0, 1'b0); tick();
    expect_now("nop8_p7", S_NONE, 3'd7, 1'b0, 1'b0); tick();
    mem_ready = 1'b1;
    opcode = 4'd13;
    fetch("nop13");
    expect_now("nop13_p4", S_INC, 3'd4, 1'b0, 1'b0);  tick();
    expect_now("nop13_p5", S_NONE, 3'd5, 1'b0, 1'b0); tick();
    expect_now("nop13_p6", S_NONE, 3'd6, 1'b0, 1'b0); tick();
    expect_now("nop13_p7", S_NONE, 3'd7, 1'b0, 1'b0); tick();

    // Three stalls, en=0 freeze, then ready on the would-be timeout cycle
    opcode = 4'd5;
    fetch("tmo_ok");
    expect_now("tmo_ok_p4", S_INC, 3'd4, 1'b0, 1'b0); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_now("tmo_ok_stall", S_RD, 3'd5, 1'b0, 1'b0); tick();
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_now("tmo_ok_frozen", S_RD, 3'd5, 1'b0, 1'b0); tick();
    end
    en = 1'b1; mem_ready = 1'b1;
    expect_now("tmo_ok_ready", S_RD, 3'd5, 1'b0, 1'b0);        tick();
    expect_now("tmo_ok_p6", S_RD, 3'd6, 1'b0, 1'b0);           tick();
    expect_now("tmo_ok_p7", S_RD | S_LDAC, 3'd7, 1'b0, 1'b0);  tick();

    // Real timeout in P5
    fetch("tmo");
    expect_now("tmo_p4", S_INC, 3'd4, 1'b0, 1'b0); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_now("tmo_stall", S_RD, 3'd5, 1'b0, 1'b0); tick();
    end
    expect_now("tmo_halted", S_HALT, 3'd4, 1'b1, 1'b1);
    resume = 1'b1; tick(); resume = 1'b0;
    expect_now("tmo_resume_ignored", S_HALT, 3'd4, 1'b1, 1'b1); tick();
    expect_now("tmo_still_halted", S_HALT, 3'd4, 1'b1, 1'b1);
    rst = 1'b0;
    expect_now("tmo_rst_clear", S_SEL, 3'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1; mem_ready = 1'b1;

    // Asynchronous reset in P6 of a JMP
    opcode = 4'd7;
    fetch("arst");
    expect_now("arst_p4", S_INC, 3'd4, 1'b0, 1'b0);  tick();
    expect_now("arst_p5", S_NONE, 3'd5, 1'b0, 1'b0); tick();
    expect_now("arst_p6", S_LDPC, 3'd6, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    expect_now("arst_async", S_SEL, 3'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;

    // en=0 for five cycles in P3
    expect_now("frz_p0", S_SEL, 3'd0, 1'b0, 1'b0);                tick();
    expect_now("frz_p1", S_SEL | S_RD, 3'd1, 1'b0, 1'b0);         tick();
    expect_now("frz_p2", S_SEL | S_RD | S_LDIR, 3'd2, 1'b0, 1'b0); tick();
    expect_now("frz_p3", S_SEL | S_RD | S_LDIR, 3'd3, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_now("frz_hold", S_SEL | S_RD | S_LDIR, 3'd3, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick();
    expect_now("frz_p4", S_INC, 3'd4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
